// File: rtl/vend_dispenser.sv
// Vend back end: one motor run per product, then one hopper handshake per Rs.5 coin of change.
// Define VEND_DISPENSER_AUDIT_EN to build the saturating vend/coin audit counters; otherwise they read 0.
module vend_dispenser #(
   parameter int MOTOR_TIMEOUT = 16,
   parameter int COIN_TIMEOUT  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] prd,
   input  logic [1:0] chng,
   input  logic       item_sensor,
   input  logic       coin_ack,
   output logic       motor_en,
   output logic [2:0] motor_sel,
   output logic       coin_req,
   output logic       busy,
   output logic       done,
   output logic       fault,
   output logic [7:0] vend_count,
   output logic [7:0] coin_count
);

   localparam int MW = $clog2(MOTOR_TIMEOUT + 1);
   localparam int CW = $clog2(COIN_TIMEOUT + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_VEND  = 3'd1;
   localparam logic [2:0] S_COIN  = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;
   localparam logic [2:0] S_FAULT = 3'd5;

   logic [2:0]    state, state_nxt;
   logic          prd_prev;
   logic [1:0]    coins_left;
   logic [MW-1:0] m_cnt;
   logic [CW-1:0] c_cnt;
   logic          trigger, m_timeout, c_timeout;

   // Only a 0 -> nonzero transition of prd starts a vend, so a held code never retriggers.
   assign trigger   = (prd != 3'b000) && !prd_prev;
   assign m_timeout = m_cnt >= MW'(MOTOR_TIMEOUT);
   assign c_timeout = c_cnt >= CW'(COIN_TIMEOUT);

   // NOTE: state_nxt takes a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (trigger) state_nxt = S_VEND;
         S_VEND: begin
            if (item_sensor)    state_nxt = (coins_left != 2'd0) ? S_COIN : S_DONE;
            else if (m_timeout) state_nxt = S_FAULT;
         end
         S_COIN: begin
            if (coin_ack)       state_nxt = (coins_left != 2'd1) ? S_GAP : S_DONE;
            else if (c_timeout) state_nxt = S_FAULT;
         end
         S_GAP:   state_nxt = S_COIN;
         S_DONE:  state_nxt = S_IDLE;
         S_FAULT: state_nxt = S_FAULT;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         prd_prev   <= 1'b0;
         motor_sel  <= 3'b000;
         coins_left <= 2'd0;
         m_cnt      <= '0;
         c_cnt      <= '0;
      end else begin
         state    <= state_nxt;
         prd_prev <= |prd;
         if (state == S_IDLE && trigger) begin
            motor_sel  <= prd;
            coins_left <= chng;
         end else if (state == S_COIN && coin_ack && coins_left != 2'd0) begin
            coins_left <= coins_left - 2'd1;
         end
         // Counters run only while in their state, so each entry starts from zero.
         m_cnt <= (state == S_VEND) ? m_cnt + MW'(1) : '0;
         c_cnt <= (state == S_COIN) ? c_cnt + CW'(1) : '0;
      end
   end

`ifdef VEND_DISPENSER_AUDIT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vend_count <= 8'd0;
         coin_count <= 8'd0;
      end else begin
         if (state == S_DONE && vend_count != 8'hFF)
            vend_count <= vend_count + 8'd1;
         if (state == S_COIN && coin_ack && coin_count != 8'hFF)
            coin_count <= coin_count + 8'd1;
      end
   end
`else
   assign vend_count = 8'd0;
   assign coin_count = 8'd0;
`endif

   assign motor_en = (state == S_VEND);
   assign coin_req = (state == S_COIN);
   assign done     = (state == S_DONE);
   assign fault    = (state == S_FAULT);
   assign busy     = (state == S_VEND) || (state == S_COIN) ||
                     (state == S_GAP)  || (state == S_DONE);

endmodule

// File: tb/tb_vend_dispenser.sv
// Directed bench for vend_dispenser: normal vends, multi-coin change, motor and coin timeouts,
// held-product non-retrigger and asynchronous reset mid-transaction.
module tb_vend_dispenser;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] prd;
   logic [1:0] chng;
   logic       item_sensor;
   logic       coin_ack;
   logic       motor_en;
   logic [2:0] motor_sel;
   logic       coin_req;
   logic       busy;
   logic       done;
   logic       fault;
   logic [7:0] vend_count;
   logic [7:0] coin_count;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef VEND_DISPENSER_AUDIT_EN
   localparam int AUD = 1;
`else
   localparam int AUD = 0;
`endif

   vend_dispenser dut (
      .clk         (clk),
      .rst         (rst),
      .prd         (prd),
      .chng        (chng),
      .item_sensor (item_sensor),
      .coin_ack    (coin_ack),
      .motor_en    (motor_en),
      .motor_sel   (motor_sel),
      .coin_req    (coin_req),
      .busy        (busy),
      .done        (done),
      .fault       (fault),
      .vend_count  (vend_count),
      .coin_count  (coin_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs and outputs are handled 1 time unit after the rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      prd = 3'd0; chng = 2'd0; item_sensor = 1'b0; coin_ack = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();
      check("rst_motor_en", motor_en, 0);
      check("rst_motor_sel", motor_sel, 0);
      check("rst_coin_req", coin_req, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_fault", fault, 0);
      check("rst_vend_count", vend_count, 0);
      check("rst_coin_count", coin_count, 0);

      // Test 1: one coin of change; cycle numbers relative to prd rising in cycle 1.
      prd = 3'd1; chng = 2'd1;
      step();                                   // cycle 2
      check("t1_motor_en_c2", motor_en, 1);
      check("t1_busy_c2", busy, 1);
      check("t1_motor_sel", motor_sel, 1);
      step();                                   // cycle 3
      check("t1_motor_en_c3", motor_en, 1);
      step(); item_sensor = 1'b1;               // cycle 4
      step(); item_sensor = 1'b0;               // cycle 5
      check("t1_motor_off_c5", motor_en, 0);
      check("t1_coin_req_c5", coin_req, 1);
      step(); coin_ack = 1'b1;                  // cycle 6
      check("t1_coin_req_c6", coin_req, 1);
      step(); coin_ack = 1'b0;                  // cycle 7
      check("t1_done_c7", done, 1);
      check("t1_coin_req_c7", coin_req, 0);
      step();                                   // cycle 8
      check("t1_done_c8", done, 0);
      check("t1_busy_c8", busy, 0);
      check("t1_vend_count", vend_count, AUD);
      check("t1_coin_count", coin_count, AUD);

      // Test 2: three coins, each acked one cycle after coin_req rises.
      do_reset();
      prd = 3'd2; chng = 2'd3;
      step(); item_sensor = 1'b1;               // VEND
      check("t2_motor_en", motor_en, 1);
      step(); item_sensor = 1'b0;               // first COIN cycle
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_req_rise%0d", i), coin_req, 1);
         step(); coin_ack = 1'b1;
         check($sformatf("t2_req_hold%0d", i), coin_req, 1);
         step(); coin_ack = 1'b0;
         check($sformatf("t2_req_gap%0d", i), coin_req, 0);
         check($sformatf("t2_done%0d", i), done, (i == 2) ? 1 : 0);
         check($sformatf("t2_busy%0d", i), busy, 1);
         if (i < 2) step();
      end
      step();
      check("t2_idle_busy", busy, 0);
      check("t2_coin_count", coin_count, 3 * AUD);
      check("t2_vend_count", vend_count, AUD);

      // Test 3: motor timeout; fault 17 cycles after motor_en rises.
      do_reset();
      prd = 3'd2; chng = 2'd0;
      step();                                   // first VEND cycle
      check("t3_motor_en", motor_en, 1);
      for (int i = 1; i <= 16; i++) begin
         step();
         check($sformatf("t3_no_fault%0d", i), fault, 0);
         check($sformatf("t3_motor_on%0d", i), motor_en, 1);
      end
      step();
      check("t3_fault", fault, 1);
      check("t3_motor_off", motor_en, 0);
      check("t3_busy", busy, 0);
      prd = 3'd0;
      step(); prd = 3'd3;
      step();
      step();
      check("t3_retrig_motor", motor_en, 0);
      check("t3_retrig_sel", motor_sel, 2);
      check("t3_fault_sticky", fault, 1);
      rst = 1'b1;
      #1;
      check("t3_rst_clears_fault", fault, 0);
      rst = 1'b0;

      // Test 4: two coins, second never acked; coin_req held through the timeout.
      do_reset();
      prd = 3'd1; chng = 2'd2;
      step(); item_sensor = 1'b1;
      step(); item_sensor = 1'b0;               // first COIN
      step(); coin_ack = 1'b1;
      step(); coin_ack = 1'b0;                  // GAP
      check("t4_gap", coin_req, 0);
      step();                                   // second COIN, counter cleared
      check("t4_req0", coin_req, 1);
      for (int i = 1; i <= 8; i++) begin
         step();
         check($sformatf("t4_req%0d", i), coin_req, 1);
      end
      step();
      check("t4_fault", fault, 1);
      check("t4_req_off", coin_req, 0);
      check("t4_coin_count", coin_count, AUD);
      check("t4_vend_count", vend_count, 0);

      // Test 5: held prd never retriggers; drop and re-raise starts a second vend.
      do_reset();
      prd = 3'd1; chng = 2'd0;
      step(); item_sensor = 1'b1;               // trigger+1: VEND
      step(); item_sensor = 1'b0;               // trigger+2: DONE (minimum duration)
      check("t5_done_min", done, 1);
      step();
      for (int i = 0; i < 10; i++) begin
         step();
         check($sformatf("t5_held_idle%0d", i), busy, 0);
      end
      prd = 3'd0;
      step(); prd = 3'd1;
      step();
      check("t5_second_vend", motor_en, 1);
      item_sensor = 1'b1;
      step(); item_sensor = 1'b0;
      check("t5_second_done", done, 1);
      step();
      check("t5_vend_count", vend_count, 2 * AUD);

      // Test 6: asynchronous reset in the middle of COIN.
      do_reset();
      prd = 3'd1; chng = 2'd1;
      step(); item_sensor = 1'b1;
      step(); item_sensor = 1'b0;
      check("t6_in_coin", coin_req, 1);
      #2 rst = 1'b1;
      #1;
      check("t6_req_drop", coin_req, 0);
      check("t6_busy_drop", busy, 0);
      check("t6_motor_drop", motor_en, 0);
      check("t6_sel_clear", motor_sel, 0);
      prd = 3'd0;
      step(); rst = 1'b0;
      step();
      check("t6_fault", fault, 0);
      check("t6_idle", busy, 0);
      prd = 3'd4;
      step();
      check("t6_new_vend", motor_en, 1);
      check("t6_new_sel", motor_sel, 4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
